// File: rtl/decimal_to_bcd_encoder.sv
// decimal_to_bcd_encoder
//   Samples ten one-hot decimal key lines through a two-flop synchronizer,
//   debounces press and release, and emits one BCD code per accepted press.
//   Accepted digits are shifted into a NUM_DIGITS-deep BCD accumulator.
//   Optional feature macro: DEC_PRIORITY_EN -- when defined, a multi-hot
//   key pattern resolves to its highest set key index instead of an Error.
module decimal_to_bcd_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [9:0]                        DECIn,
  input  logic                              Clear,
  output logic [3:0]                        BCDOut,
  output logic                              Valid,
  output logic                              Error,
  output logic [4*NUM_DIGITS-1:0]           DigitsOut,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   DigitCount,
  output logic                              Busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int DW    = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    COUNT_MAX = CW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EVAL     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // True when exactly one key line is set.
  function automatic logic is_one_hot(input logic [9:0] pat);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, pat[i]};
    end
    return (ones == 4'd1);
  endfunction

  // Index of the highest set key line (0 when none is set).
  function automatic logic [3:0] high_index(input logic [9:0] pat);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (pat[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [9:0]       sync1_q, sync2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       pat_q, pat_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             accept_s;
  logic [3:0]       digit_s;

  // Next-state, output and accumulator logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    bcd_d    = bcd_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    digits_d = digits_q;
    count_d  = count_q;
    accept_s = 1'b0;
    digit_s  = 4'd0;

    case (state_q)
      ST_IDLE: begin
        if (sync2_q != 10'd0) begin
          pat_d   = sync2_q;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEBOUNCE: begin
        if (sync2_q != pat_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EVAL: begin
        // pat_q is never zero here: DEBOUNCE only leaves towards EVAL on a
        // stable nonzero capture.
`ifdef DEC_PRIORITY_EN
        accept_s = 1'b1;
        digit_s  = high_index(pat_q);
`else
        if (is_one_hot(pat_q)) begin
          accept_s = 1'b1;
          digit_s  = high_index(pat_q);
        end else begin
          error_d = 1'b1;
        end
`endif
        cnt_d   = '0;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (sync2_q != 10'd0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (accept_s) begin
      valid_d = 1'b1;
      bcd_d   = digit_s;
    end else begin
      valid_d = 1'b0;
    end

    // Clear outranks a simultaneous new digit; the digit is still reported.
    if (Clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept_s) begin
      digits_d      = digits_q << 4;
      digits_d[3:0] = digit_s;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q;
      end
    end else begin
      digits_d = digits_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 10'd0;
      sync2_q  <= 10'd0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pat_q    <= 10'd0;
      bcd_q    <= 4'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      digits_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      sync1_q  <= DECIn;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      bcd_q    <= bcd_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign BCDOut     = bcd_q;
  assign Valid      = valid_q;
  assign Error      = error_q;
  assign DigitsOut  = digits_q;
  assign DigitCount = count_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Self-checking bench for decimal_to_bcd_encoder (DEBOUNCE_CYCLES=4,
// NUM_DIGITS=4). Honours DEC_PRIORITY_EN for the multi-hot expectations.
module tb_decimal_to_bcd_encoder;

  localparam int DC = 4;
  localparam int ND = 4;
  localparam int CW = $clog2(ND + 1);

  logic              clk;
  logic              reset_n;
  logic [9:0]        DECIn;
  logic              Clear;
  logic [3:0]        BCDOut;
  logic              Valid;
  logic              Error;
  logic [4*ND-1:0]   DigitsOut;
  logic [CW-1:0]     DigitCount;
  logic              Busy;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int ecount = 0;

  decimal_to_bcd_encoder #(.DEBOUNCE_CYCLES(DC), .NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DECIn      (DECIn),
    .Clear      (Clear),
    .BCDOut     (BCDOut),
    .Valid      (Valid),
    .Error      (Error),
    .DigitsOut  (DigitsOut),
    .DigitCount (DigitCount),
    .Busy       (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 waiting for a key, 1 settling, 2 deciding, 3 waiting for release.
  logic [9:0] m_s1, m_s2, m_pat;
  int         m_phase, m_run, m_bcd;
  bit         m_valid, m_error;
  int         digs[$];

  function automatic int top_key(input logic [9:0] p);
    int h = 0;
    for (int i = 0; i < 10; i++) if (p[i]) h = i;
    return h;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_pat = '0;
    m_phase = 0; m_run = 0; m_bcd = 0;
    m_valid = 0; m_error = 0;
    digs.delete();
  endtask

  task automatic model_step();
    logic [9:0] s;
    bit take;
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = DECIn;
    m_valid = 0;
    m_error = 0;
    take = 0;
    if (m_phase == 0) begin
      if (s != 0) begin m_pat = s; m_run = 1; m_phase = 1; end
    end else if (m_phase == 1) begin
      if (s != m_pat) m_phase = 0;
      else begin
        m_run++;
        if (m_run > DC) m_phase = 2;
      end
    end else if (m_phase == 2) begin
`ifdef DEC_PRIORITY_EN
      take = 1;
`else
      take = ($countones(m_pat) == 1);
`endif
      if (take) begin m_valid = 1; m_bcd = top_key(m_pat); end
      else m_error = 1;
      m_phase = 3; m_run = 0;
    end else begin
      if (s != 0) m_run = 0;
      else begin
        m_run++;
        if (m_run == DC) m_phase = 0;
      end
    end
    if (Clear) digs.delete();
    else if (take) begin
      digs.push_back(m_bcd);
      if (digs.size() > ND) void'(digs.pop_front());
    end
  endtask

  function automatic logic [4*ND-1:0] model_digits();
    logic [4*ND-1:0] e = '0;
    foreach (digs[k]) e = (e << 4) | (4*ND)'(digs[k]);
    return e;
  endfunction

  // Per-cycle compare against the model, 1 time unit after each rising edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) model_reset();
      else model_step();
      if (Valid) vcount++;
      if (Error) ecount++;
      check("cyc_Valid",      32'(Valid),      32'(m_valid));
      check("cyc_Error",      32'(Error),      32'(m_error));
      check("cyc_BCDOut",     32'(BCDOut),     32'(m_bcd));
      check("cyc_DigitsOut",  32'(DigitsOut),  32'(model_digits()));
      check("cyc_DigitCount", 32'(DigitCount), 32'(digs.size()));
      check("cyc_Busy",       32'(Busy),       32'(m_phase != 0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [9:0] pat);
    @(negedge clk);
    DECIn = pat;
    wait_neg(DC + 8);
    DECIn = 10'd0;
    wait_neg(DC + 6);
  endtask

  // Drives pat at a falling edge and checks Valid timing at sample edge +6/+7.
  task automatic latency_check(input logic [9:0] pat, input int key, input logic [15:0] exp_digits, input int exp_cnt);
    @(negedge clk);
    DECIn = pat;
    for (int i = 0; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) check("lat_valid_early", 32'(Valid), 32'd0);
      if (i == 7) begin
        check("lat_valid",  32'(Valid),      32'd1);
        check("lat_bcd",    32'(BCDOut),     32'(key));
        check("lat_digits", 32'(DigitsOut),  32'(exp_digits));
        check("lat_count",  32'(DigitCount), 32'(exp_cnt));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    DECIn   = 10'd0;
    Clear   = 1'b0;
    wait_neg(3);
    check("rst_bcd",    32'(BCDOut),     32'd0);
    check("rst_digits", 32'(DigitsOut),  32'd0);
    check("rst_count",  32'(DigitCount), 32'd0);
    check("rst_busy",   32'(Busy),       32'd0);
    reset_n = 1'b1;

    // Key 3 after reset: Valid exactly 7 edges after the sampling edge.
    latency_check(10'b0000001000, 3, 16'h0003, 1);
    wait_neg(DC + 4);
    DECIn = 10'd0;
    wait_neg(DC + 6);

    // Clear empties the accumulator.
    Clear = 1'b1;
    wait_neg(1);
    Clear = 1'b0;
    check("clr_digits", 32'(DigitsOut),  32'd0);
    check("clr_count",  32'(DigitCount), 32'd0);

    // Keys 1..5: oldest digit falls out.
    for (int k = 1; k <= 5; k++) press(10'd1 << k);
    check("seq_digits", 32'(DigitsOut),  32'h2345);
    check("seq_count",  32'(DigitCount), 32'd4);

    // Key 7 with 2-cycle glitches, then held.
    vcount = 0;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      DECIn = (g % 2 == 0) ? 10'b0010000000 : 10'd0;
      wait_neg(1);
    end
    wait_neg(DC + 2);
    check("glitch_no_valid", 32'(vcount), 32'd0);
    press(10'b0010000000);
    check("glitch_one_valid", 32'(vcount),    32'd1);
    check("glitch_bcd",       32'(BCDOut),    32'd7);
    check("glitch_digits",    32'(DigitsOut), 32'h3457);

    // Multi-hot keys 2 and 5.
    vcount = 0;
    ecount = 0;
    press(10'b0000100100);
`ifdef DEC_PRIORITY_EN
    check("mh_error_cnt", 32'(ecount),    32'd0);
    check("mh_valid_cnt", 32'(vcount),    32'd1);
    check("mh_bcd",       32'(BCDOut),    32'd5);
    check("mh_digits",    32'(DigitsOut), 32'h4575);
`else
    check("mh_error_cnt", 32'(ecount),    32'd1);
    check("mh_valid_cnt", 32'(vcount),    32'd0);
    check("mh_bcd",       32'(BCDOut),    32'd7);
    check("mh_digits",    32'(DigitsOut), 32'h3457);
`endif

    // Key 9 with Clear held across the accepting edge and the Valid cycle.
    vcount = 0;
    @(negedge clk);
    DECIn = 10'b1000000000;
    wait_neg(7);
    Clear = 1'b1;
    wait_neg(2);
    Clear = 1'b0;
    check("clrv_valid_cnt", 32'(vcount),     32'd1);
    check("clrv_bcd",       32'(BCDOut),     32'd9);
    check("clrv_digits",    32'(DigitsOut),  32'd0);
    check("clrv_count",     32'(DigitCount), 32'd0);
    DECIn = 10'd0;
    wait_neg(DC + 8);

    // Reset in the middle of debouncing key 6, key held past reset release.
    @(negedge clk);
    DECIn = 10'b0001000000;
    wait_neg(4);
    reset_n = 1'b0;
    #1;
    check("mrst_valid",  32'(Valid),      32'd0);
    check("mrst_bcd",    32'(BCDOut),     32'd0);
    check("mrst_digits", 32'(DigitsOut),  32'd0);
    check("mrst_count",  32'(DigitCount), 32'd0);
    check("mrst_busy",   32'(Busy),       32'd0);
    wait_neg(2);
    reset_n = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (i == 6) check("mrst_lat_early", 32'(Valid), 32'd0);
      if (i == 7) begin
        check("mrst_lat_valid",  32'(Valid),      32'd1);
        check("mrst_lat_bcd",    32'(BCDOut),     32'd6);
        check("mrst_lat_digits", 32'(DigitsOut),  32'h0006);
        check("mrst_lat_count",  32'(DigitCount), 32'd1);
      end
    end
    @(negedge clk);
    DECIn = 10'd0;
    wait_neg(DC + 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
